// File: rtl/io_seg_scan_pkg.sv
// Shared constants for the IO-board 7-segment scan driver: glyph table and pin polarity.
package io_seg_scan_pkg;

  // Active-high segment patterns, bit order {dp,g,f,e,d,c,b,a}.
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h80;

  // Hex glyphs 0..F as active-high patterns, for callers building display content.
  localparam logic [7:0] SEG_HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F,
    8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C,
    8'h39, 8'h5E, 8'h79, 8'h71
  };

  // The board pins are active-low: a lit segment or an enabled digit is driven 0.
  localparam logic PIN_ON  = 1'b0;
  localparam logic PIN_OFF = 1'b1;
  localparam logic [7:0] SEG_PINS_OFF = 8'hFF;

  // Look up the glyph for one hex nibble.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

  // Convert an active-high segment pattern to the active-low pin level.
  function automatic logic [7:0] seg_to_pins(input logic [7:0] seg);
    return ~seg;
  endfunction

endpackage

// File: rtl/io_seg_scan.sv
// Multiplexed 4-digit 7-segment scan driver with a shadow bank and frame-aligned commit.
module io_seg_scan #(
  parameter int DIGITS       = 4,
  parameter int SLOT_CYCLES  = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  input  logic [$clog2(DIGITS)-1:0] wr_idx,
  input  logic [7:0]                wr_seg,
  input  logic                      commit,
  output logic [7:0]                io_seg,
  output logic [DIGITS-1:0]         io_sel,
  output logic                      frame_start,
  output logic                      committed
);
  import io_seg_scan_pkg::*;

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(SLOT_CYCLES);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_VAL = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] DIG_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W:0]   DIG_COUNT = (IDX_W + 1)'(DIGITS);

  logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]  dig_idx_q, dig_idx_d;
  logic [7:0]        shadow_q [DIGITS];
  logic [7:0]        shadow_d [DIGITS];
  logic [7:0]        disp_q   [DIGITS];
  logic [7:0]        disp_d   [DIGITS];
  logic              pending_q, pending_d;
  logic [7:0]        io_seg_q, io_seg_d;
  logic [DIGITS-1:0] io_sel_q, io_sel_d;
  logic              frame_start_q, frame_start_d;
  logic              committed_q, committed_d;

  logic slot_wrap;
  logic frame_end;
  logic do_commit;
  logic idx_ok;

  // Next-state: scan counters, banks, commit handshake and the pin levels for the next cycle.
  always_comb begin
    slot_wrap  = (slot_cnt_q == SLOT_LAST);
    frame_end  = slot_wrap && (dig_idx_q == DIG_LAST);
    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;

    dig_idx_d = dig_idx_q;
    if (slot_wrap) begin
      dig_idx_d = (dig_idx_q == DIG_LAST) ? '0 : dig_idx_q + 1'b1;
    end

    // Writes land in the shadow bank only; an index past the last digit is dropped.
    idx_ok = ({1'b0, wr_idx} < DIG_COUNT);
    for (int i = 0; i < DIGITS; i++) begin
      shadow_d[i] = shadow_q[i];
    end
    if (wr_valid && idx_ok) begin
      shadow_d[wr_idx] = wr_seg;
    end

    // The bank copy uses shadow_d so a write in the boundary cycle is included.
    do_commit = frame_end && (pending_q || commit);
    for (int i = 0; i < DIGITS; i++) begin
      disp_d[i] = do_commit ? shadow_d[i] : disp_q[i];
    end
    pending_d   = do_commit ? 1'b0 : (pending_q || commit);
    committed_d = do_commit;

    // Outputs are derived from next-state values so the registered pins match the counters.
    frame_start_d = (slot_cnt_d == '0) && (dig_idx_d == '0);
    io_sel_d      = {DIGITS{PIN_OFF}};
    io_seg_d      = SEG_PINS_OFF;
    if (slot_cnt_d >= BLANK_VAL) begin
      io_sel_d[dig_idx_d] = PIN_ON;
      io_seg_d            = seg_to_pins(disp_d[dig_idx_d]);
    end
  end

  // State and output registers; reset blanks the pins immediately and clears both banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q    <= '0;
      dig_idx_q     <= '0;
      pending_q     <= 1'b0;
      io_seg_q      <= SEG_PINS_OFF;
      io_sel_q      <= {DIGITS{PIN_OFF}};
      frame_start_q <= 1'b0;
      committed_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        shadow_q[i] <= SEG_BLANK;
        disp_q[i]   <= SEG_BLANK;
      end
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      dig_idx_q     <= dig_idx_d;
      pending_q     <= pending_d;
      io_seg_q      <= io_seg_d;
      io_sel_q      <= io_sel_d;
      frame_start_q <= frame_start_d;
      committed_q   <= committed_d;
      for (int i = 0; i < DIGITS; i++) begin
        shadow_q[i] <= shadow_d[i];
        disp_q[i]   <= disp_d[i];
      end
    end
  end

  assign io_seg      = io_seg_q;
  assign io_sel      = io_sel_q;
  assign frame_start = frame_start_q;
  assign committed   = committed_q;

endmodule
